serial_pair_serializer_msb_first: RTL and testbench

// Upstream feeder for the MSB-first serial comparator. Accepts a pair of
// W-bit operands (a, b) over a valid/ready handshake and emits them one bit

---
 rtl/serial_pair_serializer_msb_first.sv | 69 ++++++
 tb/tb_serial_pair_serializer_msb_first.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_pair_serializer_msb_first.sv
// serial_pair_serializer_msb_first: serializes an (a, b) operand pair MSB first
// with word framing flags over valid/ready handshakes on both sides.
module serial_pair_serializer_msb_first #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_a,
   output logic         out_b,
   output logic         out_first,
   output logic         out_last
);
   localparam int CW = $clog2(W + 1);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t        state;
   logic [W-1:0]  sa, sb;
   logic [CW-1:0] cnt;
   logic          accept;
   // a last-bit transfer frees the block, so the next word can load in the same cycle
   assign in_ready = ~rst & ((state == IDLE) | (out_last & out_ready));
   assign accept   = in_valid & in_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sa        <= '0;
         sb        <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_a     <= 1'b0;
         out_b     <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept) begin
         state     <= SHIFT;
         sa        <= in_a << 1;
         sb        <= in_b << 1;
         cnt       <= CW'(W);
         out_valid <= 1'b1;
         out_a     <= in_a[W-1];
         out_b     <= in_b[W-1];
         out_first <= 1'b1;
         out_last  <= (W == 1);
      end else if (out_valid & out_ready) begin
         if (out_last) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_a     <= 1'b0;
            out_b     <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
         end else begin
            sa        <= sa << 1;
            sb        <= sb << 1;
            cnt       <= cnt - CW'(1);
            out_a     <= sa[W-1];
            out_b     <= sb[W-1];
            out_first <= 1'b0;
            out_last  <= (cnt == CW'(2));
         end
      end
   end
endmodule

// File: tb/tb_serial_pair_serializer_msb_first.sv
// tb_serial_pair_serializer_msb_first: directed and random stimulus checked
// against a queue-of-bit-pairs model of the serializer.
module tb_serial_pair_serializer_msb_first;
   localparam int W = 4;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic [W-1:0] in_a = 0, in_b = 0;
   logic in_ready, out_valid, out_a, out_b, out_first, out_last;
   logic v1 = 0, a1 = 0, b1 = 0, r1 = 1;
   logic in_ready1, out_valid1, out_a1, out_b1, out_first1, out_last1;
   int checks = 0, errors = 0;
   logic armed = 0;
   logic [3:0] q[$];

   serial_pair_serializer_msb_first #(.W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_first(out_first), .out_last(out_last));

   serial_pair_serializer_msb_first #(.W(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(in_ready1),
      .in_a(a1), .in_b(b1), .out_valid(out_valid1), .out_ready(r1),
      .out_a(out_a1), .out_b(out_b1), .out_first(out_first1), .out_last(out_last1));

   always #5 clk = ~clk;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: queue holds the {a,b,first,last} items of the word still owed downstream.
   always @(negedge clk) begin
      logic exp_rdy;
      exp_rdy = !rst && (q.size() == 0 || (q.size() == 1 && out_ready));
      if (armed) begin
         chk("m_in_ready", in_ready, exp_rdy);
         chk("m_out_valid", out_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("m_out_a", out_a, q[0][3]);
            chk("m_out_b", out_b, q[0][2]);
            chk("m_out_first", out_first, q[0][1]);
            chk("m_out_last", out_last, q[0][0]);
         end
      end
      if (rst) begin
         q.delete();
         armed = 1;
      end else if (armed) begin
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (in_valid && exp_rdy)
            for (int i = W - 1; i >= 0; i--)
               q.push_back({in_a[i], in_b[i], i == W - 1, i == 0});
      end
   end

   initial begin
      logic [3:0] ea, eb;
      logic [7:0] fm, rm;
      int nv;
      logic dec, gt;
      step();
      step();
      rst = 0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_b", out_b, 0);
      chk("rst_out_first", out_first, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_in_ready", in_ready, 1);
      step();
      // word 1010/1001, full throughput, with inputs toggled mid-word
      ea = 4'b1010; eb = 4'b1001;
      in_valid = 1; in_a = ea; in_b = eb;
      step();
      in_valid = 0;
      dec = 0; gt = 0;
      for (int k = 0; k < 4; k++) begin
         in_a = 4'($urandom); in_b = 4'($urandom);
         @(negedge clk);
         chk("t1_a", out_a, ea[3-k]);
         chk("t1_b", out_b, eb[3-k]);
         chk("t1_first", out_first, k == 0);
         chk("t1_last", out_last, k == 3);
         if (!dec && out_a != out_b) begin dec = 1; gt = out_a; end
         step();
      end
      chk("t1_a_greater_b", {dec, gt}, 3);
      // backpressure on cycles 2-4 of the word
      in_valid = 1; in_a = 4'b1010; in_b = 4'b1001;
      step();
      in_valid = 0;
      nv = 0;
      for (int k = 0; k < 9; k++) begin
         out_ready = !(k >= 1 && k <= 3);
         @(negedge clk);
         nv += int'(out_valid);
         if (k == 3) begin
            chk("t2_held_a", out_a, 0);
            chk("t2_held_b", out_b, 0);
            chk("t2_held_first", out_first, 0);
         end
         step();
      end
      out_ready = 1;
      chk("t2_valid_cycles", nv, 7);
      // back-to-back words with in_valid held
      in_valid = 1; in_a = 4'hF; in_b = 4'h0;
      step();
      in_a = 4'h3; in_b = 4'h3;
      nv = 0; fm = 0; rm = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         nv += int'(out_valid);
         fm[k] = out_first;
         rm[k] = in_ready;
         step();
         if (rm[k]) in_valid = 0;
      end
      chk("t3_valid_cycles", nv, 8);
      chk("t3_first_mask", fm, 8'h11);
      chk("t3_ready_mask", rm[6:0], 7'h08);
      @(negedge clk);
      chk("t3_idle_after", out_valid, 0);
      step();
      // reset after the second pair
      in_valid = 1; in_a = 4'hA; in_b = 4'h5;
      step();
      in_valid = 0;
      step();
      step();
      rst = 1;
      step();
      rst = 0;
      @(negedge clk);
      chk("t4_valid_after_rst", out_valid, 0);
      step();
      ea = 4'h1; eb = 4'h2;
      in_valid = 1; in_a = ea; in_b = eb;
      step();
      in_valid = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t4_a", out_a, ea[3-k]);
         chk("t4_b", out_b, eb[3-k]);
         chk("t4_valid", out_valid, 1);
         step();
      end
      // idle with toggling inputs
      for (int k = 0; k < 10; k++) begin
         in_a = 4'($urandom); in_b = 4'($urandom);
         @(negedge clk);
         chk("t6_idle_valid", out_valid, 0);
         step();
      end
      // single-bit words
      @(negedge clk);
      chk("t5_idle_ready", in_ready1, 1);
      step();
      v1 = 1; a1 = 1; b1 = 0;
      step();
      v1 = 0;
      @(negedge clk);
      chk("t5_valid", out_valid1, 1);
      chk("t5_pair", {out_a1, out_b1}, 2);
      chk("t5_first", out_first1, 1);
      chk("t5_last", out_last1, 1);
      chk("t5_ready", in_ready1, 1);
      step();
      @(negedge clk);
      chk("t5_done", out_valid1, 0);
      step();
      // random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 199) == 0);
         in_valid = ($urandom_range(0, 9) < 6);
         in_a = 4'($urandom); in_b = 4'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      rst = 0; in_valid = 0; out_ready = 1;
      repeat (10) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
